// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer driving one shared 4-bit CLA slice, LSB nibble first.
// Optional subtract mode is enabled by defining NSA_SUB_EN (adds the `sub` port).
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic             load_c;
  logic             step_c;
  logic             last_c;
  logic [WIDTH-1:0] b_load_c;
  logic             carry_load_c;

  logic [3:0]       a_nib_c;
  logic [3:0]       b_nib_c;
  logic [3:0]       gen_c;
  logic [3:0]       prop_c;
  logic [4:0]       cla_c;
  logic [3:0]       slice_sum_c;
  logic             slice_co_c;

  // Operand B and initial carry as loaded on acceptance
`ifdef NSA_SUB_EN
  always_comb begin
    b_load_c     = sub ? ~b : b;
    carry_load_c = sub ? 1'b1 : c_in;
  end
`else
  always_comb begin
    b_load_c     = b;
    carry_load_c = c_in;
  end
`endif

  // Nibble steering from the operand registers
  always_comb begin
    a_nib_c = a_reg[{idx, 2'b00} +: 4];
    b_nib_c = b_reg[{idx, 2'b00} +: 4];
  end

  // Shared 4-bit carry-look-ahead slice
  always_comb begin
    gen_c    = a_nib_c & b_nib_c;
    prop_c   = a_nib_c ^ b_nib_c;
    cla_c[0] = carry;
    cla_c[1] = gen_c[0] | (prop_c[0] & carry);
    cla_c[2] = gen_c[1] | (prop_c[1] & gen_c[0]) | (prop_c[1] & prop_c[0] & carry);
    cla_c[3] = gen_c[2] | (prop_c[2] & gen_c[1]) | (prop_c[2] & prop_c[1] & gen_c[0])
             | (prop_c[2] & prop_c[1] & prop_c[0] & carry);
    cla_c[4] = gen_c[3] | (prop_c[3] & gen_c[2]) | (prop_c[3] & prop_c[2] & gen_c[1])
             | (prop_c[3] & prop_c[2] & prop_c[1] & gen_c[0])
             | (prop_c[3] & prop_c[2] & prop_c[1] & prop_c[0] & carry);
    slice_sum_c = prop_c ^ cla_c[3:0];
    slice_co_c  = cla_c[4];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    last_c    = (idx == IDX_LAST);
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (last_c) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered status decodes of the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= (state_nxt == ST_DONE);
    end
  end

  // Operand capture, nibble stepping and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (load_c) begin
      a_reg <= a;
      b_reg <= b_load_c;
      carry <= carry_load_c;
      idx   <= '0;
    end else if (step_c) begin
      sum[{idx, 2'b00} +: 4] <= slice_sum_c;
      carry                  <= slice_co_c;
      idx                    <= idx + IDX_W'(1);
      if (last_c) begin
        c_out <= slice_co_c;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4 against an arithmetic model.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        cout16;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  logic        busy4;
  logic        done4;
  logic [3:0]  sum4;
  logic        cout4;

`ifdef NSA_SUB_EN
  logic        sub16;
  logic        sub4;
`endif

  int errors;
  int checks;

  logic [15:0] last_sum16;
  logic        last_co16;
  logic [32:0] r;

  nibble_serial_add_ctrl #(.WIDTH(16)) u16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .c_in  (cin16),
`ifdef NSA_SUB_EN
    .sub   (sub16),
`endif
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .c_out (cout16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) u4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .c_in  (cin4),
`ifdef NSA_SUB_EN
    .sub   (sub4),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .c_out (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {carry, sum} of a w-bit operation: add = a+b+cin, sub = a-b with carry meaning a>=b
  function automatic logic [32:0] model(input int unsigned w, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci, input logic s);
    logic [32:0] mask;
    logic [32:0] res;
    mask = (33'd1 << w) - 33'd1;
    if (s) begin
      res    = ({1'b0, x} - {1'b0, y}) & mask;
      res[w] = (x >= y);
    end else begin
      res = ({1'b0, x} + {1'b0, y} + 33'(ci)) & ((mask << 1) | 33'd1);
    end
    return res;
  endfunction

  task automatic scramble16();
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin16 = 1'($urandom);
  endtask

  // One operation on the 16-bit instance, entered in an idle cycle
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts);
    @(negedge clk);
    check("idle_busy16", 32'(busy16), 32'd0);
    check("idle_done16", 32'(done16), 32'd0);
    check("hold_sum16", 32'(sum16), 32'(last_sum16));
    check("hold_cout16", 32'(cout16), 32'(last_co16));
    a16 = ta; b16 = tb_v; cin16 = tc; start16 = 1'b1;
`ifdef NSA_SUB_EN
    sub16 = ts;
`endif
    r = model(16, 32'(ta), 32'(tb_v), tc, ts);
    @(posedge clk);
    #1 start16 = 1'b0;
    scramble16();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("run_busy16", 32'(busy16), 32'd1);
      check("run_done16", 32'(done16), 32'd0);
      scramble16();
    end
    @(negedge clk);
    check("done16", 32'(done16), 32'd1);
    check("done_busy16", 32'(busy16), 32'd0);
    check("sum16", 32'(sum16), 32'(r[15:0]));
    check("cout16", 32'(cout16), 32'(r[16]));
    last_sum16 = r[15:0];
    last_co16  = r[16];
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc, input logic ts);
    @(negedge clk);
    check("idle_busy4", 32'(busy4), 32'd0);
    a4 = ta; b4 = tb_v; cin4 = tc; start4 = 1'b1;
`ifdef NSA_SUB_EN
    sub4 = ts;
`endif
    r = model(4, 32'(ta), 32'(tb_v), tc, ts);
    @(posedge clk);
    #1 start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    @(negedge clk);
    check("run_busy4", 32'(busy4), 32'd1);
    check("run_done4", 32'(done4), 32'd0);
    @(negedge clk);
    check("done4", 32'(done4), 32'd1);
    check("done_busy4", 32'(busy4), 32'd0);
    check("sum4", 32'(sum4), 32'(r[3:0]));
    check("cout4", 32'(cout4), 32'(r[4]));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last_sum16 = '0;
    last_co16  = 1'b0;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
`ifdef NSA_SUB_EN
    sub16 = 1'b0;
    sub4  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_done16", 32'(done16), 32'd0);
    check("rst_sum16", 32'(sum16), 32'd0);
    check("rst_cout16", 32'(cout16), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_sum4", 32'(sum4), 32'd0);
    rst = 1'b0;

    // Directed boundary cases, including back-to-back start in the first idle cycle
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run16(16'h1234, 16'h4321, 1'b1, 1'b0);
    run16(16'h8000, 16'h8000, 1'b0, 1'b0);
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    run16(16'h0000, 16'h0000, 1'b0, 1'b0);

    // Randomized additions
    for (int n = 0; n < 12; n++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end

    // Start held high: one operation per 6 cycles, operands sampled only at acceptance
    start16 = 1'b1;
    for (int op = 0; op < 4; op++) begin
      logic [15:0] ha;
      logic [15:0] hb;
      logic        hc;
      @(negedge clk);
      check("held_idle_busy", 32'(busy16), 32'd0);
      check("held_idle_done", 32'(done16), 32'd0);
      ha = 16'($urandom); hb = 16'($urandom); hc = 1'($urandom);
      a16 = ha; b16 = hb; cin16 = hc;
      r = model(16, 32'(ha), 32'(hb), hc, 1'b0);
      @(posedge clk);
      #1 scramble16();
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("held_busy", 32'(busy16), 32'd1);
        check("held_done_early", 32'(done16), 32'd0);
        scramble16();
      end
      @(negedge clk);
      check("held_done", 32'(done16), 32'd1);
      check("held_sum", 32'(sum16), 32'(r[15:0]));
      check("held_cout", 32'(cout16), 32'(r[16]));
      scramble16();
      last_sum16 = r[15:0];
      last_co16  = r[16];
    end
    start16 = 1'b0;

    // Reset in the second RUN cycle aborts the operation
    run16(16'hFFFF, 16'hFFF0, 1'b1, 1'b0);
    @(negedge clk);
    a16 = 16'h7777; b16 = 16'h1111; cin16 = 1'b1; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy16), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy16), 32'd0);
    check("abort_done", 32'(done16), 32'd0);
    check("abort_sum", 32'(sum16), 32'd0);
    check("abort_cout", 32'(cout16), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done16), 32'd0);
      check("abort_no_busy", 32'(busy16), 32'd0);
    end
    last_sum16 = '0;
    last_co16  = 1'b0;
    run16(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    // Single-nibble instance
    run4(4'h9, 4'h8, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    end

`ifdef NSA_SUB_EN
    run16(16'h0005, 16'h0007, 1'b1, 1'b1);
    run16(16'h0007, 16'h0005, 1'b0, 1'b1);
    run16(16'h1234, 16'h1234, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    run4(4'h3, 4'h9, 1'b1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
